mul_shift_add: RTL and testbench

Iterative unsigned shift-and-add multiplier that sits beside the combinational ALU in the execute stage. It consumes the same left-shifted multiplicand values the ALU's left-shift path produces, one shift step per clock. It produces the full 2N-bit product of two N-bit operands. Operands enter and the product leaves through valid/ready handshakes, so the pipeline control can stall on it for multi-cycle multiply instructions.

---
 rtl/mul_shift_add_if.sv | 23 ++
 rtl/mul_shift_add.sv | 84 ++++++++
 tb/tb_mul_shift_add.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mul_shift_add_if.sv
// Operand/product handshake bundle for the shift-and-add multiplier.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready.
interface mul_shift_add_if #(
  parameter int N = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-and-add multiplier, one multiplicand shift per clock.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_shift_add #(
  parameter int N = 32
) (
  input  logic               clk,
  input  logic               rst,
  mul_shift_add_if.slave     bus,
  output logic [1:0]         dbg_state
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  count;
  logic           last_step;

`ifdef MUL_EARLY_EXIT_EN
  // Once the multiplier has no set bits left, further steps add nothing.
  assign last_step = (count == LAST) || ((mplier >> 1) == '0);
`else
  assign last_step = (count == LAST);
`endif

  assign bus.product = acc;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      count         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            mcand        <= {{N{1'b0}}, bus.a};
            mplier       <= bus.b;
            acc          <= '0;
            count        <= '0;
            bus.in_ready <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // Product of two N-bit values fits in 2N bits, so the sum never carries out.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last_step) begin
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_shift_add.sv
// Randomized self-checking bench for mul_shift_add against a plain a*b reference.
// Define MUL_EARLY_EXIT_EN for both bench and RTL to check the early-exit latency.
module tb_mul_shift_add;
  localparam int N = 32;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  mul_shift_add_if #(.N(N)) bus();

  mul_shift_add #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int accepted     = 0;
  int delivered    = 0;
  logic [2*N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [2*N-1:0] got, input logic [2*N-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference latency in edges from the accept edge to out_valid being visible.
  function automatic int exp_lat(input logic [N-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int steps;
    steps = 1;
    for (int i = 0; i < N; i++) if (b[i]) steps = i + 1;
    return steps + 1;
`else
    return N + 1;
`endif
  endfunction

  function automatic logic [N-1:0] rand_operand();
    int kind;
    kind = $urandom_range(0, 5);
    case (kind)
      0: return '0;
      1: return N'(1);
      2: return '1;
      3: return N'(1) << $urandom_range(0, N - 1);
      default: return N'($urandom);
    endcase
  endfunction

  // Driver: present one operand pair, wait for the product, optionally stall the consumer.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall);
    int edges;
    int waited;
    logic [2*N-1:0] exp;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_idle", 2*N'(bus.in_ready), 2*N'(1));
    exp_q.push_back((2*N)'(a) * (2*N)'(b));
    exp = exp_q[0];
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = (stall == 0);
    @(negedge clk);
    accepted++;
    bus.in_valid = 1'b0;
    check("in_ready_busy", 2*N'(bus.in_ready), '0);
    edges = 1;
    while (!bus.out_valid && edges < 200) begin
      // Operands offered while busy must be ignored.
      bus.in_valid = $urandom_range(0, 1);
      bus.a = N'($urandom);
      bus.b = N'($urandom);
      @(negedge clk);
      edges++;
    end
    bus.in_valid = 1'b0;
    check("latency", 2*N'(edges), 2*N'(exp_lat(b)));
    check("product", bus.product, exp);
    delivered++;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = N'(1);
      bus.b = N'(1);
      @(negedge clk);
      check("stall_valid", 2*N'(bus.out_valid), 2*N'(1));
      check("stall_product", bus.product, exp);
      check("stall_in_ready", 2*N'(bus.in_ready), '0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("retire_valid", 2*N'(bus.out_valid), '0);
    check("retire_idle", 2*N'(dbg_state), '0);
    void'(exp_q.pop_front());
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 2*N'(bus.in_ready), 2*N'(1));
    check("rst_out_valid", 2*N'(bus.out_valid), '0);
    check("rst_product", bus.product, '0);
    check("rst_state", 2*N'(dbg_state), '0);

    // Directed cases
    run_op(N'(3), N'(5), 0);
    run_op('1, '1, 0);
    check("allones_ref", (2*N)'(64'hFFFFFFFE00000001), (2*N)'({N{1'b1}}) * (2*N)'({N{1'b1}}));
    run_op(N'(32'h80000000), N'(2), 0);
    run_op(N'(7), N'(6), 10);
    run_op(N'(12345), '0, 0);
    run_op(N'(32'hDEADBEEF), N'(1), 0);
    run_op(N'(32'h1234), N'(32'h80000000), 0);

    // Reset in the middle of a multiply drops the result.
    while (!bus.in_ready) @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = N'(100);
    bus.b         = N'(200);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 2*N'(bus.in_ready), 2*N'(1));
    check("midrst_out_valid", 2*N'(bus.out_valid), '0);
    check("midrst_product", bus.product, '0);
    check("midrst_state", 2*N'(dbg_state), '0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    check("midrst_no_delivery", 2*N'(n), '0);
    run_op(N'(9), N'(9), 0);

    // Random operand pairs, occasionally with a short consumer stall.
    for (int i = 0; i < 1000; i++) begin
      run_op(rand_operand(), rand_operand(), ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
    end

    check("deliver_count", 2*N'(delivered), 2*N'(accepted));
    check("queue_empty", 2*N'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
